// File: rtl/diag_fault_map_writer_pkg.sv
// Shared definitions for the diagnostic fault-map writer.
//   state_t       : controller states
//   summary_addr  : eNVM word index of the column-summary word (one past the rows)
//   row_flag_bit  : bit position of the row fault flag inside a row word
// Word layout for an N-wide array: bit N = row fault flag, bits N-1:0 = PE/column bits.
package diag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SETTLE,
        WRITE,
        DONE
    } state_t;

    localparam int unsigned PE_LSB = 0;

    function automatic int unsigned summary_addr(input int unsigned n);
        return n;
    endfunction

    function automatic int unsigned row_flag_bit(input int unsigned n);
        return n;
    endfunction

endpackage

// File: rtl/diag_fault_map_writer_if.sv
// eNVM write port: valid/ready handshake carrying one fault-map word.
//   envm_wr_valid : word request from the writer
//   envm_wr_ready : eNVM accepts the word when valid && ready
//   envm_wr_addr  : word address (rows 0..N-1, summary word at N)
//   envm_wr_data  : N+1 bit word
// master = writer side, slave = eNVM side.
interface diag_fault_map_writer_if
    import diag_pkg::*;
#(
    parameter int N          = 8,
    parameter int ADDR_WIDTH = $clog2(N + 1)
);

    logic                  envm_wr_valid;
    logic                  envm_wr_ready;
    logic [ADDR_WIDTH-1:0] envm_wr_addr;
    logic [N:0]            envm_wr_data;

    modport master (
        output envm_wr_valid,
        output envm_wr_addr,
        output envm_wr_data,
        input  envm_wr_ready
    );

    modport slave (
        input  envm_wr_valid,
        input  envm_wr_addr,
        input  envm_wr_data,
        output envm_wr_ready
    );

endinterface

// File: rtl/diag_fault_map_writer_popcount.sv
// popcount_n: combinational count of set bits in an N-bit vector.
//   vec   : input vector
//   count : number of ones in vec
module popcount_n #(
    parameter int N = 8,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count = count + W'(vec[i]);
        end
    end

endmodule

// File: rtl/diag_fault_map_writer.sv
// diag_fault_map_writer: consumer end of the diagnostic loop chains.
// Runs the chains for one pass (N cycles), captures each row's PE fault vector,
// latches the row/column fault summaries, then writes N row words plus one
// column-summary word to the eNVM over a valid/ready port.
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : run request, honoured only when idle
//   diag_en                  : start_en for the loop chains (high during the scan)
//   single_pe_detection      : per-row PE fault vector, one row per scan cycle
//   row_fault_detection      : row fault vector, sampled in the settle cycle
//   column_fault_detection   : column fault vector, sampled in the settle cycle
//   envm                     : eNVM write port (master side)
//   busy                     : high outside IDLE
//   done                     : one-cycle pulse after the summary word is accepted
//   fault_count              : faulty PEs found in the last scan
//   any_fault                : fault_count != 0 or any latched column fault
module diag_fault_map_writer
    import diag_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE + 1),
    parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE * SYSTOLIC_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     diag_en,
    input  logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
    input  logic [SYSTOLIC_SIZE-1:0] row_fault_detection,
    input  logic [SYSTOLIC_SIZE-1:0] column_fault_detection,
    diag_fault_map_writer_if.master  envm,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_WIDTH-1:0]     fault_count,
    output logic                     any_fault
);

    localparam int N     = SYSTOLIC_SIZE;
    localparam int IDX_W = $clog2(N);
    localparam int PC_W  = $clog2(N + 1);

    if (SYSTOLIC_SIZE < 3) begin : g_size_check
        $error("diag_fault_map_writer: SYSTOLIC_SIZE must be >= 3");
    end

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      row_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [N-1:0]          pe_buf_q [N];
    logic [N-1:0]          rf_q;
    logic [N-1:0]          cf_q;
    logic [PC_W-1:0]       pe_pop;
    logic                  last_row;
    logic                  last_word;
    logic [IDX_W-1:0]      addr_idx;

    assign last_row  = (row_q == IDX_W'(N - 1));
    assign last_word = (addr_q == ADDR_WIDTH'(summary_addr(N)));
    assign addr_idx  = addr_q[IDX_W-1:0];

    popcount_n #(
        .N(N),
        .W(PC_W)
    ) u_popcount (
        .vec  (single_pe_detection),
        .count(pe_pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        diag_en            = 1'b0;
        busy               = 1'b1;
        done               = 1'b0;
        envm.envm_wr_valid = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                diag_en = 1'b1;
                if (last_row) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = WRITE;
            end
            WRITE: begin
                envm.envm_wr_valid = 1'b1;
                if (envm.envm_wr_ready && last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address and data are forced to zero outside WRITE so every output reads 0 after reset.
    always_comb begin
        envm.envm_wr_addr = '0;
        envm.envm_wr_data = '0;
        if (state_q == WRITE) begin
            envm.envm_wr_addr = addr_q;
            if (last_word) begin
                envm.envm_wr_data[N-1:PE_LSB] = cf_q;
            end else begin
                envm.envm_wr_data[row_flag_bit(N)] = rf_q[addr_idx];
                envm.envm_wr_data[N-1:PE_LSB]      = pe_buf_q[addr_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            addr_q      <= '0;
            rf_q        <= '0;
            cf_q        <= '0;
            fault_count <= '0;
            any_fault   <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                pe_buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        row_q       <= '0;
                        fault_count <= '0;
                        any_fault   <= 1'b0;
                    end
                end
                SCAN: begin
                    pe_buf_q[row_q] <= single_pe_detection;
                    fault_count     <= fault_count + CNT_WIDTH'(pe_pop);
                    row_q           <= row_q + 1'b1;
                end
                SETTLE: begin
                    rf_q      <= row_fault_detection;
                    cf_q      <= column_fault_detection;
                    any_fault <= (fault_count != '0) || (|column_fault_detection);
                    addr_q    <= '0;
                end
                WRITE: begin
                    if (envm.envm_wr_ready && !last_word) begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diag_fault_map_writer.sv
// Self-checking bench for diag_fault_map_writer (N=8): randomized and directed
// runs compared every cycle against a transaction-level model of the writer.
module tb_diag_fault_map_writer;

    localparam int N  = 8;
    localparam int AW = $clog2(N + 1);
    localparam int CW = $clog2(N * N + 1);
    localparam int DW = N + 1;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  pe    = '0;
    logic [N-1:0]  rf    = '0;
    logic [N-1:0]  cf    = '0;
    logic          diag_en;
    logic          busy;
    logic          done;
    logic          any_fault;
    logic [CW-1:0] fault_count;

    diag_fault_map_writer_if #(.N(N), .ADDR_WIDTH(AW)) envm ();

    diag_fault_map_writer #(
        .SYSTOLIC_SIZE(N),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .diag_en               (diag_en),
        .single_pe_detection   (pe),
        .row_fault_detection   (rf),
        .column_fault_detection(cf),
        .envm                  (envm),
        .busy                  (busy),
        .done                  (done),
        .fault_count           (fault_count),
        .any_fault             (any_fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: m_t counts cycles since the accepted start
    // (0..N-1 scan, N settle, >N write phase), -1 when idle.
    int           m_t    = -1;
    bit           m_done = 1'b0;
    int           m_widx = 0;
    int           m_fc   = 0;
    bit           m_af   = 1'b0;
    logic [N-1:0] m_pe [N];
    logic [N-1:0] m_rf = '0;
    logic [N-1:0] m_cf = '0;

    function automatic logic [DW-1:0] exp_word(input int i);
        if (i == N) return {1'b0, m_cf};
        return {m_rf[i], m_pe[i]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t = -1; m_done = 1'b0; m_widx = 0; m_fc = 0; m_af = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_t < 0) begin
            if (start) begin
                m_t = 0; m_fc = 0; m_af = 1'b0;
            end
        end else if (m_t < N) begin
            m_pe[m_t] = pe;
            m_fc += $countones(pe);
            m_t++;
        end else if (m_t == N) begin
            m_rf = rf; m_cf = cf;
            m_af = (m_fc != 0) || (cf != '0);
            m_widx = 0;
            m_t++;
        end else if (envm.envm_wr_ready) begin
            if (m_widx == N) begin
                m_done = 1'b1; m_t = -1;
            end else begin
                m_widx++;
            end
        end
    end

    int            cyc = 0;
    always @(posedge clk) cyc++;

    int            done_cnt  = 0;
    int            start_cyc = 0;
    int            lat_last  = 0;
    logic [DW-1:0] obs [$];

    always @(negedge clk) begin
        bit wr;
        wr = (m_t > N);
        chk("diag_en",     diag_en,            (m_t >= 0 && m_t < N));
        chk("busy",        busy,               (m_t >= 0) || m_done);
        chk("valid",       envm.envm_wr_valid, wr);
        chk("addr",        envm.envm_wr_addr,  wr ? m_widx : 0);
        chk("data",        envm.envm_wr_data,  wr ? exp_word(m_widx) : '0);
        chk("done",        done,               m_done);
        chk("fault_count", fault_count,        m_fc);
        chk("any_fault",   any_fault,          m_af);
        if (envm.envm_wr_valid === 1'b1 && envm.envm_wr_ready === 1'b1 && !rst)
            obs.push_back(envm.envm_wr_data);
        if (done === 1'b1) begin
            done_cnt++;
            lat_last = cyc + 1 - start_cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            pe = N'($urandom); rf = N'($urandom); cf = N'($urandom);
            envm.envm_wr_ready = 1'($urandom);
            tick();
        end
    endtask

    // kind: 0 no faults, 1 single PE, 2 row/col summary, 3 backpressure,
    //       4 random, 5 start held high, 6 reset mid-write at addr 4
    task automatic do_run(input int kind);
        int d0;
        bit fin;
        d0  = done_cnt;
        fin = 1'b0;
        obs.delete();
        for (int k = 0; k < 300 && !fin; k++) begin
            start = (k == 0) || (kind == 5) || (kind == 4 && $urandom_range(3) == 0);
            if (kind == 3 || kind == 4) begin
                pe = N'($urandom); rf = N'($urandom); cf = N'($urandom);
            end else begin
                pe = '0; rf = '0; cf = '0;
            end
            if (kind == 1 && k == 4) pe = 8'h04;
            if (kind == 2 && k == N + 1) begin
                rf = 8'h20; cf = 8'h81;
            end
            if (kind == 3) begin
                if (k >= N + 4 && k <= N + 6) envm.envm_wr_ready = 1'b0;
                else if (k >= N + 7)          envm.envm_wr_ready = ((k - N - 7) % 2 == 0);
                else                          envm.envm_wr_ready = 1'b1;
            end else if (kind == 4) begin
                envm.envm_wr_ready = 1'($urandom);
            end else begin
                envm.envm_wr_ready = 1'b1;
            end
            if (k == 0) start_cyc = cyc + 1;
            if (kind == 6 && k == N + 6) rst = 1'b1;
            tick();
            if (kind == 6 && k == N + 6) begin
                rst = 1'b0;
                fin = 1'b1;
                chk("rst_busy",        busy,               0);
                chk("rst_diag_en",     diag_en,            0);
                chk("rst_valid",       envm.envm_wr_valid, 0);
                chk("rst_addr",        envm.envm_wr_addr,  0);
                chk("rst_data",        envm.envm_wr_data,  0);
                chk("rst_done",        done,               0);
                chk("rst_fault_count", fault_count,        0);
                chk("rst_any_fault",   any_fault,          0);
                chk("rst_words_before", obs.size(),        4);
            end
            if (done_cnt != d0) fin = 1'b1;
        end
        if (!fin) chk("run_timeout", 0, 1);
        start = 1'b0;
    endtask

    initial begin
        envm.envm_wr_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy",        busy,               0);
        chk("reset_valid",       envm.envm_wr_valid, 0);
        chk("reset_fault_count", fault_count,        0);
        chk("reset_any_fault",   any_fault,          0);
        rst = 1'b0;
        idle(2);

        do_run(0);
        chk("nofault_latency", lat_last, 19);
        chk("nofault_words",   obs.size(), 9);
        for (int i = 0; i < obs.size(); i++) chk("nofault_word", obs[i], 9'h000);
        chk("nofault_count", fault_count, 0);
        chk("nofault_any",   any_fault,   0);
        idle(2);

        do_run(1);
        chk("single_words", obs.size(), 9);
        for (int i = 0; i < obs.size(); i++)
            chk("single_word", obs[i], (i == 3) ? 9'h004 : 9'h000);
        chk("single_count", fault_count, 1);
        chk("single_any",   any_fault,   1);
        chk("single_model_count", m_fc, 1);
        idle(1);

        do_run(2);
        chk("summary_word5", obs[5], 9'h100);
        chk("summary_word8", obs[8], 9'h081);
        chk("summary_count", fault_count, 0);
        chk("summary_any",   any_fault,   1);
        idle(3);

        do_run(3);
        chk("bp_words", obs.size(), 9);
        for (int i = 0; i < obs.size(); i++) chk("bp_word", obs[i], exp_word(i));
        idle(2);

        begin
            int d0;
            d0 = done_cnt;
            do_run(5);
            chk("held_start_words", obs.size(), 9);
            chk("held_start_dones", done_cnt - d0, 1);
            idle(1);
            chk("held_start_idle", busy, 0);
        end
        idle(2);

        do_run(6);
        do_run(4);
        chk("after_rst_words", obs.size(), 9);
        chk("after_rst_first", obs[0], exp_word(0));

        for (int r = 0; r < 20; r++) begin
            do_run(4);
            chk("rand_words", obs.size(), 9);
            idle($urandom_range(3));
        end

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
